// File: rtl/pwm_multichannel.sv
// pwm_multichannel: multi-channel PWM with a shared counter and shadowed duty/period/mode registers
module pwm_multichannel #(
  parameter int CHANNELS = 16,
  parameter int CNT_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEFAULT_TOP = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [CNT_W-1:0]    wr_data,
  input  logic [CHANNELS-1:0] en_out,
  input  logic [CHANNELS-1:0] en_pwm,
  output logic [CHANNELS-1:0] out,
  output logic                cycle_start
);
  localparam logic [ADDR_W-1:0] A_TOP = ADDR_W'(CHANNELS);
  localparam logic [ADDR_W-1:0] A_MODE = ADDR_W'(CHANNELS + 1);
  logic [CNT_W-1:0] r_cnt, r_top, r_top_p, w_nxt;
  logic r_mode, r_mode_p, r_dir, w_dn, w_bnd;
  logic [CNT_W-1:0] r_duty [CHANNELS];
  logic [CNT_W-1:0] r_duty_p [CHANNELS];
  logic [CHANNELS-1:0] w_lt;
  always_comb begin
    w_dn = r_dir | (r_cnt == r_top);
    w_nxt = (r_mode && r_top != '0) ? (w_dn ? r_cnt - CNT_W'(1) : r_cnt + CNT_W'(1))
                                     : ((r_cnt == r_top) ? '0 : r_cnt + CNT_W'(1));
    w_bnd = (w_nxt == '0);
    w_lt = '0;
    for (int i = 0; i < CHANNELS; i++) w_lt[i] = r_cnt < r_duty[i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_dir <= 1'b0;
      r_top <= CNT_W'(DEFAULT_TOP);
      r_top_p <= CNT_W'(DEFAULT_TOP);
      r_mode <= 1'b0;
      r_mode_p <= 1'b0;
      out <= '0;
      cycle_start <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_duty[i] <= '0;
        r_duty_p[i] <= '0;
      end
    end else begin
      r_cnt <= w_nxt;
      r_dir <= r_mode & ~w_bnd & w_dn;
      cycle_start <= w_bnd;
      out <= en_out & (~en_pwm | w_lt);
      if (w_bnd) begin
        r_top <= r_top_p;
        r_mode <= r_mode_p;
      end
      if (wr_en && wr_addr == A_TOP) r_top_p <= wr_data;
      if (wr_en && wr_addr == A_MODE) r_mode_p <= wr_data[0];
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_bnd) r_duty[i] <= r_duty_p[i];
        if (wr_en && wr_addr == ADDR_W'(i)) r_duty_p[i] <= wr_data;
      end
    end
  end
endmodule

// File: tb/tb_pwm_multichannel.sv
// tb_pwm_multichannel: directed self-checking bench for pwm_multichannel
module tb_pwm_multichannel;
  localparam int CH = 16;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0;
  logic [5:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [CH-1:0] en_out = '1, en_pwm = '1, out;
  logic cycle_start;
  int total = 0, bad = 0;
  int n, hi, cs, any;
  logic [63:0] pat;
  pwm_multichannel #(.CHANNELS(CH), .CNT_W(8), .ADDR_W(6), .DEFAULT_TOP(255)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .en_out(en_out), .en_pwm(en_pwm), .out(out), .cycle_start(cycle_start)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int a, input int d);
    wr_en = 1'b1;
    wr_addr = 6'(a);
    wr_data = 8'(d);
    tick();
    wr_en = 1'b0;
  endtask
  task automatic wait_cs(input int ch, output int cnt, output int h);
    cnt = 0;
    h = 0;
    do begin
      tick();
      cnt++;
      h += int'(out[ch]);
    end while (!cycle_start && cnt < 2000);
    total++;
    if (cycle_start !== 1'b1) begin
      bad++;
      $display("FAIL cs_timeout got=%b want=1", cycle_start);
    end
  endtask
  task automatic measure(input int len, input int ch, output int h, output int c, output int a, output logic [63:0] p);
    h = 0;
    c = 0;
    a = 0;
    p = '0;
    for (int i = 0; i < len; i++) begin
      tick();
      h += int'(out[ch]);
      c += int'(cycle_start);
      a += int'(out != '0);
      if (i < 64) p[i] = out[ch];
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if (out !== '0 || cycle_start !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold got=%h/%b want=0/0", out, cycle_start);
    end
    rst = 1'b0;
    measure(255, 0, hi, cs, any, pat);
    total++;
    if (cs !== 0 || any !== 0) begin
      bad++;
      $display("FAIL reset_first_period got cs=%0d any=%0d want 0/0", cs, any);
    end
    tick();
    total++;
    if (cycle_start !== 1'b1) begin
      bad++;
      $display("FAIL first_wrap got=%b want=1", cycle_start);
    end
  endtask
  task automatic test_edge;
    wr(0, 128);
    wait_cs(0, n, hi);
    total++;
    if (n !== 255) begin
      bad++;
      $display("FAIL edge_wait got=%0d want=255", n);
    end
    measure(256, 0, hi, cs, any, pat);
    total++;
    if (hi !== 128 || cs !== 1 || cycle_start !== 1'b1) begin
      bad++;
      $display("FAIL edge_duty got hi=%0d cs=%0d end=%b want 128/1/1", hi, cs, cycle_start);
    end
  endtask
  task automatic test_shadow;
    repeat (50) tick();
    wr(3, 64);
    tick();
    wr(3, 192);
    wait_cs(3, n, hi);
    total++;
    if (n !== 203 || hi !== 0) begin
      bad++;
      $display("FAIL shadow_current got n=%0d hi=%0d want 203/0", n, hi);
    end
    measure(256, 3, hi, cs, any, pat);
    total++;
    if (hi !== 192 || cs !== 1) begin
      bad++;
      $display("FAIL shadow_next got hi=%0d cs=%0d want 192/1", hi, cs);
    end
  endtask
  task automatic test_boundary_write;
    repeat (255) tick();
    wr(16, 9);
    total++;
    if (cycle_start !== 1'b1) begin
      bad++;
      $display("FAIL bw_align got=%b want=1", cycle_start);
    end
    measure(256, 0, hi, cs, any, pat);
    total++;
    if (cs !== 1 || cycle_start !== 1'b1) begin
      bad++;
      $display("FAIL bw_old_period got cs=%0d end=%b want 1/1", cs, cycle_start);
    end
    measure(30, 0, hi, cs, any, pat);
    total++;
    if (cs !== 3 || hi !== 30) begin
      bad++;
      $display("FAIL bw_new_period got cs=%0d hi=%0d want 3/30", cs, hi);
    end
  endtask
  task automatic test_center;
    wr(16, 10);
    wr(4, 4);
    wr(17, 1);
    wait_cs(4, n, hi);
    measure(20, 4, hi, cs, any, pat);
    total++;
    if (pat[19:0] !== 20'hE000F || hi !== 7 || cs !== 1) begin
      bad++;
      $display("FAIL center_pattern got pat=%h hi=%0d cs=%0d want e000f/7/1", pat[19:0], hi, cs);
    end
    repeat (5) tick();
    wr(17, 0);
    wait_cs(4, n, hi);
    total++;
    if (n !== 14 || hi !== 3) begin
      bad++;
      $display("FAIL center_to_edge got n=%0d hi=%0d want 14/3", n, hi);
    end
    measure(11, 4, hi, cs, any, pat);
    total++;
    if (pat[10:0] !== 11'h00F || cs !== 1) begin
      bad++;
      $display("FAIL edge_after_center got pat=%h cs=%0d want 00f/1", pat[10:0], cs);
    end
  endtask
  task automatic test_extremes;
    wr(16, 100);
    wr(5, 255);
    wait_cs(5, n, hi);
    measure(202, 5, hi, cs, any, pat);
    total++;
    if (hi !== 202 || cs !== 2) begin
      bad++;
      $display("FAIL full_duty got hi=%0d cs=%0d want 202/2", hi, cs);
    end
    wr(16, 0);
    wait_cs(5, n, hi);
    measure(5, 5, hi, cs, any, pat);
    total++;
    if (cs !== 5 || hi !== 5) begin
      bad++;
      $display("FAIL top_zero got cs=%0d hi=%0d want 5/5", cs, hi);
    end
    total++;
    if (out[8] !== 1'b0) begin
      bad++;
      $display("FAIL duty_zero got=%b want=0", out[8]);
    end
    en_out[5] = 1'b0;
    en_pwm[5] = 1'b0;
    en_pwm[8] = 1'b0;
    tick();
    total++;
    if (out[5] !== 1'b0 || out[8] !== 1'b1) begin
      bad++;
      $display("FAIL enables got out5=%b out8=%b want 0/1", out[5], out[8]);
    end
    en_pwm[5] = 1'b1;
    tick();
    total++;
    if (out[5] !== 1'b0) begin
      bad++;
      $display("FAIL en_out_off got=%b want=0", out[5]);
    end
    en_out = '1;
    en_pwm = '1;
    tick();
  endtask
  task automatic test_reset_mid;
    wr(16, 50);
    wr(17, 1);
    wr(16, 20);
    wr(0, 7);
    rst = 1'b1;
    wr(0, 200);
    tick();
    total++;
    if (out !== '0 || cycle_start !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got=%h/%b want=0/0", out, cycle_start);
    end
    rst = 1'b0;
    wr(18, 5);
    wait_cs(0, n, hi);
    total++;
    if (n !== 255 || hi !== 0) begin
      bad++;
      $display("FAIL mid_reset_period got n=%0d hi=%0d want 255/0", n, hi);
    end
    measure(256, 0, hi, cs, any, pat);
    total++;
    if (any !== 0 || cs !== 1 || cycle_start !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_pending got any=%0d cs=%0d end=%b want 0/1/1", any, cs, cycle_start);
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_edge();
    test_shadow();
    test_boundary_write();
    test_center();
    test_extremes();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pwm_multichannel.md
# pwm_multichannel

Parametrised multi-channel PWM generator with a shared period counter. It offers edge-aligned and center-aligned modes and double-buffered (shadow) duty, period and mode registers that take effect only at period boundaries. Configuration arrives over a single-cycle write port from the SPI register front end. Enables are direct inputs, and registered channel outputs drive the output pads.

## Interface
Parameters:
- CHANNELS, 16: number of PWM channels (1–32).
- CNT_W, 8: counter, duty and period width in bits.
- ADDR_W, 6: write address width; must satisfy 2^ADDR_W ≥ CHANNELS+2.
- DEFAULT_TOP, 255: reset value of the period register (TOP).

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  reset, synchronous and active-high.
- wr_en  in  1  write strobe, one write per cycle.
- wr_addr  in  ADDR_W  register address.
- wr_data  in  CNT_W  write data.
- en_out  in  CHANNELS  per-channel output enable; 0 forces the output low.
- en_pwm  in  CHANNELS  per-channel PWM enable; 0 with en_out=1 forces the output high.
- out  out  CHANNELS  registered channel outputs.
- cycle_start  out  1  one-cycle pulse in the first cycle of each period.

## Operation
- Register map:
  - 0..CHANNELS-1: duty[ch].
  - CHANNELS: TOP.
  - CHANNELS+1: mode; bit0=1 selects center-aligned, other bits are ignored.
  - Writes to any other address are ignored.
- Each register has a pending copy, written by wr_en, and an active copy used by the generator.
- All active copies load from their pending copies on the edge where cnt becomes 0 at a period boundary. A boundary is the edge mode wrap, or the center mode down-count reaching 0.
- A write in the same cycle as a load is not captured by that load. It stays in the pending copy and applies at the next boundary.
- Edge mode: cnt runs 0,1,…,TOP,0,… for a period of TOP+1 cycles.
- Center mode: cnt runs 0,1,…,TOP,TOP-1,…,1,0,… with an internal direction bit, for a period of 2·TOP cycles.
  - The direction bit flips to down at cnt==TOP and to up at cnt==0.
  - On a mode change at a boundary, the direction bit is set to up.
- TOP=0 in either mode: cnt stays 0, every cycle is a boundary, and cycle_start is held high.
- Channel function, evaluated on registered cnt and the active copies:
  - en_out[ch]=0 → 0.
  - Otherwise en_pwm[ch]=0 → 1.
  - Otherwise → (cnt < duty[ch]).
- Duty boundary cases:
  - duty=0 → constantly low.
  - duty > TOP → constantly high, i.e. 100%, no glitch at wrap.
  - Edge high time = min(duty, TOP+1) cycles per period.
  - Center high time = 2·duty−1 cycles per period for 1 ≤ duty ≤ TOP, symmetric about cnt==0.
- Comparisons are unsigned, CNT_W bits; there is no arithmetic overflow because cnt never exceeds TOP.
- en_out and en_pwm are not shadowed and act immediately, subject only to the output register.

## Timing
- Output latency:
  - out in cycle n+1 reflects cnt, the active registers and the en_* inputs sampled in cycle n.
  - cycle_start is asserted in the cycle in which cnt==0 at a boundary, and is registered alongside out.
- A write takes effect on out at the first boundary strictly after the write cycle, plus one cycle of output latency.
- Reset values, held while rst is high:
  - Counter state: cnt=0, direction=up.
  - Duty registers: all pending and active copies of duty=0.
  - Period and mode: TOP=DEFAULT_TOP, mode=edge.
  - Outputs: out=0, cycle_start=0.
- First cycle after reset release:
  - cnt=0 and out=0.
  - cycle_start stays low until the first wrap; the reset load counts as the initial load.
- Reset asserted mid-period aborts the period immediately and discards all pending writes.
- Writes issued while rst is high are ignored.

## Test plan
- Edge, TOP=255, duty[0]=128, en_out=en_pwm=1 → out[0] high for 128 of every 256 cycles; cycle_start period is 256.
- Shadowing: write duty[3]=64 mid-period, then 192 two cycles later → the current period is unchanged; the next period shows 192 high cycles; 64 never appears.
- Write coincident with boundary: write TOP=9 in the cnt-becomes-0 load cycle → the following period is still 256 cycles and subsequent periods are 10 cycles.
- Center mode, TOP=10, duty=4 → period 20, out high for 7 consecutive cycles centred on cnt==0; a mode switch back to edge occurs only at a boundary with direction up.
- Extremes: duty=0 → always 0; duty=255 with TOP=100 → always 1 with no wrap glitch; TOP=0 → cycle_start constantly 1; en_out=0 → 0 regardless of en_pwm; en_out=1, en_pwm=0 → 1 one cycle after the change.
- Reset mid-period with pending writes → the cycle after deassert has out=0, cnt=0 and mode=edge; pending values are lost and the invalid address CHANNELS+2 write has no effect.
